elink_tmr_voter: RTL
====================

# elink_tmr_voter

Parametrised triple-modular-redundancy voter for NCH independent elink trigger channels, each carried as three replicas. It produces a registered per-channel majority word, a 2-bit agreement quality and the identity of an outvoted replica. It also keeps saturating per-replica fault counters and raises a sticky alarm on persistent loss of majority. It sits between the triplicated elink deserialisers and the trigger-primitive path, and its counters and alarms feed slow control.

## Interface
- WIDTH, 10, data bits per channel word
- NCH, 2, number of independent channels
- CNT_W, 16, width of every fault counter
- ALARM_N, 8, consecutive valid no-majority cycles that set a channel alarm (≥1)
- HOLD_LAST, 1, output on no majority: 0 = replica 1, 1 = last majority word of that channel
- clk  in  1  the only clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  input words valid this cycle
- data_in1  in  NCH*WIDTH  replica 1; channel c at bits [c*WIDTH +: WIDTH]
- data_in2  in  NCH*WIDTH  replica 2, same packing
- data_in3  in  NCH*WIDTH  replica 3, same packing
- cnt_clr  in  1  synchronous clear of all counters, run counters and alarms
- valid_out  out  1  registered valid_in
- voted  out  NCH*WIDTH  voted word per channel
- quality  out  2*NCH  per channel: 2 = all agree, 1 = two agree, 0 = none
- bad_rep  out  2*NCH  per channel: outvoted replica 1/2/3, or 0 if none or no majority
- err_cnt  out  3*NCH*CNT_W  minority counters; index (c*3+r) for replica r+1
- nomaj_cnt  out  NCH*CNT_W  no-majority cycle counter per channel
- alarm  out  NCH  sticky per-channel persistent-disagreement flag

## Operation
- Vote per channel, evaluated in priority order:
  - d1==d2==d3: word = d1, q = 2, bad = 0.
  - d1==d2: word = d1, q = 1, bad = 3.
  - d1==d3: word = d1, q = 1, bad = 2.
  - d2==d3: word = d2, q = 1, bad = 1.
  - Otherwise: word = d1 if HOLD_LAST = 0, else last_good[c]. q = 0, bad = 0.
- last_good[c] loads the word on every valid cycle with q ≥ 1. It resets to 0.
- valid_in = 0: voted, quality and bad_rep hold their values. Counters, run counters, last_good and alarms do not change.
- Counters, on valid cycles only:
  - err_cnt[c][bad-1] increments when q = 1.
  - nomaj_cnt[c] increments when q = 0.
  - All counters saturate at 2^CNT_W−1 and never wrap.
- Alarm run counter per channel:
  - Width is clog2(ALARM_N+1).
  - Increments on a valid q = 0 cycle, saturating at ALARM_N.
  - Clears on a valid q ≥ 1 cycle.
  - Invalid cycles neither break nor extend a run.
- alarm[c] sets on the edge where the run counter reaches ALARM_N. It stays set until cnt_clr or rst, even if majority returns.
- cnt_clr = 1 zeroes err_cnt, nomaj_cnt, run counters and alarm. It has priority over a same-cycle increment; that event is not counted.
- cnt_clr does not affect voted, quality, bad_rep, valid_out or last_good. Voting still happens on that cycle.
- Channels are fully independent; no cross-channel logic.

## Timing
- Latency: 1 cycle. Inputs at edge k appear on voted/quality/bad_rep/valid_out after edge k.
- Counters and alarm reflect the cycle-k event after edge k, aligned with valid_out.
- Reset (async assert, sampled release): every output is 0, including voted, quality, bad_rep, valid_out, all counters and alarm. last_good and run counters are also 0.
- Reset mid-run clears a partial alarm run. After release a full ALARM_N fresh cycles are needed.
- No combinational path from input to output.

## Test plan
- WIDTH=10, NCH=2, channel 0 = 0x155 on all replicas, valid: next cycle voted[9:0]=0x155, quality=2, bad_rep=0, counters unchanged.
- Channel 1 with d1=0x0AA, d2=0x0AB, d3=0x0AA: voted=0x0AA, q=1, bad_rep=2, err_cnt index 4 = 1. Repeat 3 valid and 2 invalid cycles: count = 4.
- HOLD_LAST=1:
  - Channel 0 agrees on 0x123, then d1/d2/d3 = 0x001/0x002/0x003 for 8 valid cycles.
  - voted = 0x123, q = 0, nomaj_cnt = 8, alarm[0] rises after the 8th edge.
  - Restore majority: alarm stays 1. Pulse cnt_clr: alarm and counters return to 0.
- Alarm run: 7 no-majority, 1 majority, 7 no-majority with an invalid cycle inserted: alarm stays 0. One more no-majority: alarm = 1.
- Saturation: CNT_W=3, 10 valid no-majority cycles: nomaj_cnt = 7. cnt_clr together with a no-majority cycle: nomaj_cnt = 0.
- Assert rst asynchronously mid-stream between edges: all outputs 0 immediately. First vote after release has 1-cycle latency, and last_good = 0 (HOLD_LAST=1 no-majority gives voted = 0).

Source files
------------

// File: rtl/elink_tmr_voter.sv
// Triple-modular-redundancy voter for NCH elink channels. It registers a majority word, a quality
// code and the outvoted replica, and keeps saturating fault counters plus a sticky no-majority alarm.
module elink_tmr_voter #(
  parameter int WIDTH     = 10,
  parameter int NCH       = 2,
  parameter int CNT_W     = 16,
  parameter int ALARM_N   = 8,
  parameter int HOLD_LAST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [NCH*WIDTH-1:0]     data_in1,
  input  logic [NCH*WIDTH-1:0]     data_in2,
  input  logic [NCH*WIDTH-1:0]     data_in3,
  input  logic                     cnt_clr,
  output logic                     valid_out,
  output logic [NCH*WIDTH-1:0]     voted,
  output logic [2*NCH-1:0]         quality,
  output logic [2*NCH-1:0]         bad_rep,
  output logic [3*NCH*CNT_W-1:0]   err_cnt,
  output logic [NCH*CNT_W-1:0]     nomaj_cnt,
  output logic [NCH-1:0]           alarm
);

  localparam int              RUN_W   = $clog2(ALARM_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALARM_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
    if (v == RUN_MAX) return v;
    return v + RUN_W'(1);
  endfunction

  logic r_vld_p1;

  // p0 -> p1: valid travels with the voted data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= valid_in;
  end

  assign valid_out = r_vld_p1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] w_d1, w_d2, w_d3, w_word;
    logic [1:0]       w_q, w_bad;
    logic [RUN_W-1:0] w_run_nxt;

    logic [WIDTH-1:0] r_voted_p1, r_last_good;
    logic [1:0]       r_qual_p1, r_bad_p1;
    logic [CNT_W-1:0] r_err [3];
    logic [CNT_W-1:0] r_nomaj;
    logic [RUN_W-1:0] r_run;
    logic             r_alarm;

    assign w_d1      = data_in1[c*WIDTH +: WIDTH];
    assign w_d2      = data_in2[c*WIDTH +: WIDTH];
    assign w_d3      = data_in3[c*WIDTH +: WIDTH];
    assign w_run_nxt = run_inc(r_run);

    // Priority order matters: a replica pair containing d1 wins over d2==d3.
    always_comb begin
      w_word = w_d1;
      w_q    = 2'd0;
      w_bad  = 2'd0;
      if (w_d1 == w_d2 && w_d2 == w_d3) begin
        w_q = 2'd2;
      end else if (w_d1 == w_d2) begin
        w_q   = 2'd1;
        w_bad = 2'd3;
      end else if (w_d1 == w_d3) begin
        w_q   = 2'd1;
        w_bad = 2'd2;
      end else if (w_d2 == w_d3) begin
        w_word = w_d2;
        w_q    = 2'd1;
        w_bad  = 2'd1;
      end else if (HOLD_LAST != 0) begin
        w_word = r_last_good;
      end
    end

    // p0 -> p1: vote result, history and counters
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_voted_p1  <= '0;
        r_qual_p1   <= '0;
        r_bad_p1    <= '0;
        r_last_good <= '0;
        r_err[0]    <= '0;
        r_err[1]    <= '0;
        r_err[2]    <= '0;
        r_nomaj     <= '0;
        r_run       <= '0;
        r_alarm     <= 1'b0;
      end else begin
        if (valid_in) begin
          r_voted_p1 <= w_word;
          r_qual_p1  <= w_q;
          r_bad_p1   <= w_bad;
          if (w_q != 2'd0) r_last_good <= w_word;
        end
        // Clear wins over a same-cycle event, which is then simply lost.
        if (cnt_clr) begin
          r_err[0] <= '0;
          r_err[1] <= '0;
          r_err[2] <= '0;
          r_nomaj  <= '0;
          r_run    <= '0;
          r_alarm  <= 1'b0;
        end else if (valid_in) begin
          if (w_q == 2'd1) begin
            case (w_bad)
              2'd1:    r_err[0] <= sat_inc(r_err[0]);
              2'd2:    r_err[1] <= sat_inc(r_err[1]);
              2'd3:    r_err[2] <= sat_inc(r_err[2]);
              default: ;
            endcase
          end
          if (w_q == 2'd0) begin
            r_nomaj <= sat_inc(r_nomaj);
            r_run   <= w_run_nxt;
            if (w_run_nxt == RUN_MAX) r_alarm <= 1'b1;
          end else begin
            r_run <= '0;
          end
        end
      end
    end

    assign voted[c*WIDTH +: WIDTH]         = r_voted_p1;
    assign quality[c*2 +: 2]               = r_qual_p1;
    assign bad_rep[c*2 +: 2]               = r_bad_p1;
    assign err_cnt[(c*3+0)*CNT_W +: CNT_W] = r_err[0];
    assign err_cnt[(c*3+1)*CNT_W +: CNT_W] = r_err[1];
    assign err_cnt[(c*3+2)*CNT_W +: CNT_W] = r_err[2];
    assign nomaj_cnt[c*CNT_W +: CNT_W]     = r_nomaj;
    assign alarm[c]                        = r_alarm;
  end

endmodule
